// File: rtl/dco_bank_if.sv
// Write port and per-channel status bundle for dco_bank.
interface dco_bank_if #(
  parameter int CH = 2,
  parameter int W  = 8
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic          code_vld;
  logic [CW-1:0] code_ch;
  logic [W-1:0]  code;
  logic [CH-1:0] dco_out;
  logic [CH-1:0] wrap;
  logic [CH-1:0] pend;

  modport master (output code_vld, code_ch, code, input dco_out, wrap, pend);
  modport slave  (input code_vld, code_ch, code, output dco_out, wrap, pend);
endinterface

// File: rtl/dco_bank.sv
// Multi-channel square-wave DCO with shared prescaler and glitch-free period updates.
// Optional DCO_SYNC_EN adds a sync input that phase-aligns all running channels.
module dco_bank #(
  parameter int CH  = 2,
  parameter int W   = 8,
  parameter int DIV = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
`ifdef DCO_SYNC_EN
  input  logic       sync,
`endif
  dco_bank_if.slave  bus
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt_reg, div_cnt_next;
  logic          tick;
  logic          sync_hit;

  always_comb begin
    div_cnt_next = div_cnt_reg;
    if (en)
      div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
  end

  assign tick = en && (div_cnt_reg == DIV_LAST);

`ifdef DCO_SYNC_EN
  assign sync_hit = tick && sync;
`else
  assign sync_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) div_cnt_reg <= '0;
    else        div_cnt_reg <= div_cnt_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [W-1:0] active_reg, active_next;
      logic [W-1:0] pending_reg, pending_next;
      logic [W-1:0] cnt_reg, cnt_next;
      logic         pend_reg, pend_next;
      logic         out_reg, out_next;
      logic         wrap_reg, wrap_next;
      logic         wr, idle, last, start, boundary, consume;
      logic [W-1:0] applied;

      // A channel is IDLE whenever active is zero; every other value means RUN.
      always_comb begin
        wr       = bus.code_vld && (bus.code_ch == CW'(gi));
        idle     = (active_reg == '0);
        last     = (cnt_reg == active_reg - 1'b1);
        start    = tick && idle && pend_reg;
        boundary = tick && !idle && last && !out_reg;
        consume  = start || boundary || sync_hit;
        applied  = pend_reg ? pending_reg : active_reg;

        active_next  = active_reg;
        cnt_next     = cnt_reg;
        out_next     = out_reg;
        wrap_next    = 1'b0;
        pending_next = wr ? bus.code : pending_reg;
        // A write landing on the boundary cycle survives for the next boundary.
        pend_next    = wr ? 1'b1 : (consume ? 1'b0 : pend_reg);

        if (consume) begin
          active_next = applied;
          cnt_next    = '0;
          out_next    = (applied != '0);
          wrap_next   = (applied != '0);
        end else if (tick && !idle) begin
          if (last) begin
            cnt_next = '0;
            out_next = !out_reg;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          active_reg  <= '0;
          pending_reg <= '0;
          cnt_reg     <= '0;
          pend_reg    <= 1'b0;
          out_reg     <= 1'b0;
          wrap_reg    <= 1'b0;
        end else begin
          active_reg  <= active_next;
          pending_reg <= pending_next;
          cnt_reg     <= cnt_next;
          pend_reg    <= pend_next;
          out_reg     <= out_next;
          wrap_reg    <= wrap_next;
        end
      end

      assign bus.dco_out[gi] = out_reg;
      assign bus.wrap[gi]    = wrap_reg;
      assign bus.pend[gi]    = pend_reg;
    end
  endgenerate
endmodule

// File: tb/tb_dco_bank.sv
// Directed bench: DIV=1 two-channel instance and DIV=5 three-channel instance.
module tb_dco_bank;
  logic clk = 1'b0;
  logic rst_n;
  logic en_a, en_b;
`ifdef DCO_SYNC_EN
  logic sync_a, sync_b;
`endif
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  dco_bank_if #(.CH(2), .W(8)) if_a ();
  dco_bank_if #(.CH(3), .W(8)) if_b ();

  dco_bank #(.CH(2), .W(8), .DIV(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_a),
`ifdef DCO_SYNC_EN
    .sync  (sync_a),
`endif
    .bus   (if_a)
  );

  dco_bank #(.CH(3), .W(8), .DIV(5)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_b),
`ifdef DCO_SYNC_EN
    .sync  (sync_b),
`endif
    .bus   (if_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic ch, input logic [7:0] val);
    if_a.code_vld = 1'b1;
    if_a.code_ch  = ch;
    if_a.code     = val;
  endtask

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b0;
`ifdef DCO_SYNC_EN
    sync_a = 1'b0;
    sync_b = 1'b0;
`endif
    if_a.code_vld = 1'b1; if_a.code_ch = 1'b0; if_a.code = 8'd7;
    if_b.code_vld = 1'b1; if_b.code_ch = 2'd0; if_b.code = 8'd7;

    // Reset held for two clocks with writes asserted
    for (int r = 0; r < 2; r++) begin
      step();
      chk("rst_out_a", if_a.dco_out, 0);
      chk("rst_wrap_a", if_a.wrap, 0);
      chk("rst_pend_a", if_a.pend, 0);
      chk("rst_pend_b", if_b.pend, 0);
    end
    rst_n = 1'b1;
    if_a.code_vld = 1'b0;
    if_b.code_vld = 1'b0;
    for (int r = 0; r < 3; r++) begin
      step();
      chk("idle_out_a", if_a.dco_out, 0);
      chk("idle_pend_a", if_a.pend, 0);
    end

    // Basic: code 3 on ch0
    wr_a(1'b0, 8'd3);
    step();
    chk("basic_pend", if_a.pend, 2'b01);
    chk("basic_out_pre", if_a.dco_out, 0);
    if_a.code_vld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("basic_out0", if_a.dco_out[0], (i % 6) < 3);
      chk("basic_wrap0", if_a.wrap[0], (i % 6) == 0);
      chk("basic_out1", if_a.dco_out[1], 0);
      if (i == 0) chk("basic_pend_clr", if_a.pend, 0);
    end
    step();
    chk("basic_rise", if_a.dco_out[0], 1);
    chk("basic_rise_wrap", if_a.wrap[0], 1);

    // Glitch-free update to 5 during the high phase
    wr_a(1'b0, 8'd5);
    for (int j = 0; j < 16; j++) begin
      step();
      if (j == 0) if_a.code_vld = 1'b0;
      if (j < 5) begin
        chk("upd_out_old", if_a.dco_out[0], j < 2);
        chk("upd_pend_old", if_a.pend[0], 1);
        chk("upd_wrap_old", if_a.wrap[0], 0);
      end else begin
        chk("upd_out_new", if_a.dco_out[0], ((j - 5) % 10) < 5);
        chk("upd_wrap_new", if_a.wrap[0], ((j - 5) % 10) == 0);
        chk("upd_pend_new", if_a.pend[0], 0);
      end
    end

    // Collision: pending=2, then write 4 on the boundary cycle
    wr_a(1'b0, 8'd2);
    step();
    if_a.code_vld = 1'b0;
    chk("col_pend2", if_a.pend[0], 1);
    repeat (8) step();
    chk("col_low_before", if_a.dco_out[0], 0);
    wr_a(1'b0, 8'd4);
    step();
    if_a.code_vld = 1'b0;
    chk("col_bnd_out", if_a.dco_out[0], 1);
    chk("col_bnd_wrap", if_a.wrap[0], 1);
    chk("col_bnd_pend", if_a.pend[0], 1);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k < 4) begin
        chk("col_run2_out", if_a.dco_out[0], k < 2);
        chk("col_run2_pend", if_a.pend[0], 1);
      end else begin
        chk("col_run4_out", if_a.dco_out[0], ((k - 4) % 8) < 4);
        chk("col_run4_wrap", if_a.wrap[0], ((k - 4) % 8) == 0);
        chk("col_run4_pend", if_a.pend[0], 0);
      end
    end

    // Stop: write 0, cycle completes, channel goes idle
    wr_a(1'b0, 8'd0);
    step();
    if_a.code_vld = 1'b0;
    chk("stop_pend", if_a.pend[0], 1);
    repeat (6) step();
    chk("stop_low", if_a.dco_out[0], 0);
    chk("stop_pend_hold", if_a.pend[0], 1);
    step();
    chk("stop_bnd_out", if_a.dco_out[0], 0);
    chk("stop_bnd_wrap", if_a.wrap[0], 0);
    chk("stop_bnd_pend", if_a.pend[0], 0);
    repeat (4) step();
    chk("stop_idle_out", if_a.dco_out, 0);

    // Prescaler DIV=5, write while disabled, out-of-range channel ignored
    if_b.code_vld = 1'b1; if_b.code_ch = 2'd0; if_b.code = 8'd1;
    step();
    chk("pre_pend", if_b.pend, 3'b001);
    if_b.code_ch = 2'd3; if_b.code = 8'd9;
    step();
    chk("pre_badch_pend", if_b.pend, 3'b001);
    chk("pre_badch_out", if_b.dco_out, 0);
    if_b.code_vld = 1'b0;
    en_b = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("pre_out", if_b.dco_out, {2'b00, (i >= 5) && (((i - 5) % 10) < 5)});
      chk("pre_wrap", if_b.wrap, {2'b00, (i >= 5) && (((i - 5) % 10) == 0)});
      if (i == 5) chk("pre_pend_clr", if_b.pend, 0);
    end
    repeat (2) step();
    chk("pre_low", if_b.dco_out[0], 0);

    // Enable low for 7 clocks freezes everything
    en_b = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("frz_out", if_b.dco_out[0], 0);
      chk("frz_wrap", if_b.wrap[0], 0);
    end
    en_b = 1'b1;
    step();
    chk("res_out0", if_b.dco_out[0], 0);
    step();
    chk("res_out1", if_b.dco_out[0], 0);
    step();
    chk("res_rise", if_b.dco_out[0], 1);
    chk("res_wrap", if_b.wrap[0], 1);
    repeat (4) step();
    chk("res_high", if_b.dco_out[0], 1);
    step();
    chk("res_fall", if_b.dco_out[0], 0);

`ifdef DCO_SYNC_EN
    wr_a(1'b0, 8'd3);
    step();
    wr_a(1'b1, 8'd5);
    step();
    if_a.code_vld = 1'b0;
    repeat (7) step();
    sync_a = 1'b1;
    step();
    sync_a = 1'b0;
    chk("sync_out", if_a.dco_out, 2'b11);
    chk("sync_wrap", if_a.wrap, 2'b11);
    step();
    chk("sync_wrap_end", if_a.wrap, 2'b00);
    chk("sync_out_hold", if_a.dco_out, 2'b11);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
